// File: rtl/alu_ctrl_pkg.sv
// Shared types and constants for the multi-cycle ALU sequencer.
// ERR state exists only when ALU_CTRL_DIVZERO_EN is defined.
package alu_ctrl_pkg;

  typedef enum logic [3:0] {
    S_IDLE,
    S_LOAD,
    S_EVAL,
    S_ADD,
    S_SUB,
    S_SHR,
    S_SHL,
    S_SETQ,
    S_CORR,
    S_OUT_LO,
    S_OUT_HI
`ifdef ALU_CTRL_DIVZERO_EN
    , S_ERR
`endif
  } state_e;

  localparam logic [1:0] OP_ADD = 2'b00;
  localparam logic [1:0] OP_SUB = 2'b01;
  localparam logic [1:0] OP_MUL = 2'b10;
  localparam logic [1:0] OP_DIV = 2'b11;

  localparam int C_LOAD   = 0;
  localparam int C_ADD    = 1;
  localparam int C_SUB    = 2;
  localparam int C_SHR    = 3;
  localparam int C_SHL    = 4;
  localparam int C_SETQ   = 5;
  localparam int C_CNT    = 6;
  localparam int C_CORR   = 7;
  localparam int C_OUT_LO = 8;
  localparam int C_OUT_HI = 9;
  localparam int CTRL_W   = 10;

endpackage

// File: rtl/alu_iter_counter.sv
// Iteration counter for MUL/DIV loops; saturates at WIDTH-1 (never wraps).
module alu_iter_counter #(
  parameter int WIDTH = 8
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_clear,
  input  logic i_inc,
  output logic o_last
);
  localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  logic [CNT_W-1:0] r_cnt;

  always_ff @(posedge i_clk) begin
    if (i_rst || i_clear) r_cnt <= '0;
    else if (i_inc && !o_last) r_cnt <= r_cnt + 1'b1;
  end

  assign o_last = (r_cnt == CNT_W'(WIDTH - 1));

endmodule

// File: rtl/alu_seq_ctrl.sv
// Sequencer for add/sub/Booth-multiply/non-restoring-divide on the A/Q/M datapath.
// Optional ALU_CTRL_DIVZERO_EN: divide with dvz=1 aborts through ERR.
module alu_seq_ctrl
  import alu_ctrl_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [1:0]        sel,
  input  logic              q_0,
  input  logic              q_min1,
  input  logic              sign,
  input  logic              dvz,
  output logic [CTRL_W-1:0] c,
  output logic [1:0]        op,
  output logic              ready,
  output logic              done,
  output logic              err
);
  state_e     r_state, w_next;
  logic [1:0] r_op;
  logic       w_last;
  logic       w_after_alu_mul, w_after_alu_div;

`ifndef ALU_CTRL_DIVZERO_EN
  logic w_unused_dvz;
  assign w_unused_dvz = dvz;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_op    <= OP_ADD;
    end else begin
      r_state <= w_next;
      if (r_state == S_IDLE && start) r_op <= sel;
    end
  end

  assign op = r_op;

  alu_iter_counter #(.WIDTH(WIDTH)) u_cnt (
    .i_clk   (clk),
    .i_rst   (rst),
    .i_clear (r_state == S_LOAD),
    .i_inc   (c[C_CNT]),
    .o_last  (w_last)
  );

  assign w_after_alu_mul = (r_op == OP_MUL);
  assign w_after_alu_div = (r_op == OP_DIV);

  always_comb begin
    w_next = r_state;
    c      = '0;
    ready  = 1'b0;
    done   = 1'b0;
    err    = 1'b0;
    case (r_state)
      S_IDLE: begin
        ready = 1'b1;
        if (start) w_next = S_LOAD;
      end
      S_LOAD: begin
        c[C_LOAD] = 1'b1;
        case (r_op)
          OP_ADD:  w_next = S_ADD;
          OP_SUB:  w_next = S_SUB;
          OP_MUL:  w_next = S_EVAL;
`ifdef ALU_CTRL_DIVZERO_EN
          default: w_next = dvz ? S_ERR : S_SHL;
`else
          default: w_next = S_SHL;
`endif
        endcase
      end
      S_EVAL: begin
        case ({q_0, q_min1})
          2'b10:   w_next = S_SUB;
          2'b01:   w_next = S_ADD;
          default: w_next = S_SHR;
        endcase
      end
      // SUB reuses the adder with inverted M and carry-in, so C_ADD rides along.
      S_ADD, S_SUB: begin
        c[C_ADD] = 1'b1;
        c[C_SUB] = (r_state == S_SUB);
        if (w_after_alu_mul)      w_next = S_SHR;
        else if (w_after_alu_div) w_next = S_SETQ;
        else                      w_next = S_OUT_LO;
      end
      S_SHR: begin
        c[C_SHR] = 1'b1;
        c[C_CNT] = 1'b1;
        w_next   = w_last ? S_OUT_LO : S_EVAL;
      end
      S_SHL: begin
        c[C_SHL] = 1'b1;
        w_next   = sign ? S_ADD : S_SUB;
      end
      S_SETQ: begin
        c[C_SETQ] = 1'b1;
        c[C_CNT]  = 1'b1;
        if (w_last) w_next = sign ? S_CORR : S_OUT_LO;
        else        w_next = S_SHL;
      end
      S_CORR: begin
        c[C_CORR] = 1'b1;
        c[C_ADD]  = 1'b1;
        w_next    = S_OUT_LO;
      end
      S_OUT_LO: begin
        c[C_OUT_LO] = 1'b1;
        if (r_op[1]) w_next = S_OUT_HI;
        else begin
          done   = 1'b1;
          w_next = S_IDLE;
        end
      end
      S_OUT_HI: begin
        c[C_OUT_HI] = 1'b1;
        done        = 1'b1;
        w_next      = S_IDLE;
      end
`ifdef ALU_CTRL_DIVZERO_EN
      S_ERR: begin
        err    = 1'b1;
        done   = 1'b1;
        w_next = S_IDLE;
      end
`endif
      default: w_next = S_IDLE;
    endcase
  end

endmodule
